sdiv_seq_ctrl: RTL and testbench

Multicycle controller for the 32-bit signed divider. It runs a single non-restoring divider layer for one iteration per clock, replacing the fully unrolled array. It converts the operands to magnitudes, sequences 32 add/subtract iterations, applies the final remainder correction and sign fix-up, and returns the quotient and remainder to the ALU over a start/done handshake.

---
 rtl/sdiv_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_sdiv_seq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sdiv_seq_ctrl.sv
// Multicycle 32-bit signed divider: one non-restoring iteration per clock behind a start/done handshake.
// Optional SDIV_EARLY_EXIT_EN: short-circuit when |dividend| < |divisor|.
`timescale 1ns/1ps
module sdiv_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, SIGN, DONE} state_t;

   function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
      return ~v + DATA_W'(1);
   endfunction

   function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] ? f_neg(v) : v;
   endfunction

   state_t                     state_q, state_d;
   logic        [DATA_W-1:0]   dvd_q, dvd_d;
   logic        [DATA_W-1:0]   dvs_q, dvs_d;
   logic                       sq_q, sq_d;
   logic                       sr_q, sr_d;
   logic signed [DATA_W:0]     p_q, p_d;
   logic        [DATA_W-1:0]   q_q, q_d;
   logic        [DATA_W-1:0]   m_q, m_d;
   logic        [4:0]          cnt_q, cnt_d;
   logic        [DATA_W-1:0]   quo_q, quo_d;
   logic        [DATA_W-1:0]   rem_q, rem_d;
   logic                       dbz_q, dbz_d;

   logic        [DATA_W-1:0]   mag_dvd, mag_dvs;
   logic signed [DATA_W:0]     d_ext, p_sh, p_step;

   assign mag_dvd = f_abs(dvd_q);
   assign mag_dvs = f_abs(dvs_q);
   assign d_ext   = $signed({1'b0, m_q});
   // Non-restoring step: the sign of P before the shift picks add or subtract.
   assign p_sh    = $signed({p_q[DATA_W-1:0], q_q[DATA_W-1]});
   assign p_step  = p_q[DATA_W] ? (p_sh + d_ext) : (p_sh - d_ext);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         p_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         p_q     <= p_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      p_d     = p_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               sq_d    = dividend[DATA_W-1] ^ divisor[DATA_W-1];
               sr_d    = dividend[DATA_W-1];
               dbz_d   = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            m_d = mag_dvs;
            // Short paths preload Q/P so SIGN rebuilds remainder = dividend unchanged.
            if (dvs_q == '0) begin
               q_d     = '1;
               sq_d    = 1'b0;
               p_d     = $signed({1'b0, mag_dvd});
               dbz_d   = 1'b1;
               state_d = SIGN;
            end
`ifdef SDIV_EARLY_EXIT_EN
            else if (mag_dvd < mag_dvs) begin
               q_d     = '0;
               sq_d    = 1'b0;
               p_d     = $signed({1'b0, mag_dvd});
               state_d = SIGN;
            end
`endif
            else begin
               q_d     = mag_dvd;
               p_d     = '0;
               cnt_d   = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            p_d   = p_step;
            q_d   = {q_q[DATA_W-2:0], ~p_step[DATA_W]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            if (p_q[DATA_W]) p_d = p_q + d_ext;
            state_d = SIGN;
         end
         SIGN: begin
            quo_d   = sq_q ? f_neg(q_q) : q_q;
            rem_d   = sr_q ? f_neg(p_q[DATA_W-1:0]) : p_q[DATA_W-1:0];
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sdiv_seq_ctrl.sv
// Self-checking bench for sdiv_seq_ctrl: directed corner cases plus random operands against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_sdiv_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int n_tests = 0;
   int n_fail  = 0;

   sdiv_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit signed division truncates toward zero; results wrap to 32 bits.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z, output int lat);
      longint la, lb;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      if (lb == 0) begin
         q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 2;
      end else begin
         q = 32'(la / lb); r = 32'(la % lb); z = 1'b0; lat = 35;
`ifdef SDIV_EARLY_EXIT_EN
         begin
            longint aa, ab;
            aa = (la < 0) ? -la : la;
            ab = (lb < 0) ? -lb : lb;
            if (aa < ab) lat = 2;
         end
`endif
      end
   endfunction

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input bit inject);
      logic [31:0] eq, er;
      logic        ez;
      int          el, lat;
      model(a, b, eq, er, ez, el);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      check_val({tag, ".busy0"}, 32'(busy), 32'd1);
      lat = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (inject) begin
            if (k == 9 || k == 34) begin
               start = 1'b1; dividend = 32'd77; divisor = 32'd5;
            end else start = 1'b0;
         end
         if (done) begin lat = k; break; end
      end
      start = 1'b0;
      check_val({tag, ".lat"}, 32'(lat), 32'(el));
      check_val({tag, ".quo"}, quotient, eq);
      check_val({tag, ".rem"}, remainder, er);
      check_val({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
      check_val({tag, ".busy_done"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      check_val({tag, ".done_pulse"}, 32'(done), 32'd0);
      check_val({tag, ".idle"}, 32'(busy), 32'd0);
      check_val({tag, ".held"}, quotient, eq);
   endtask

   initial begin
      logic [31:0] a, b;
      int k1, k2;
      bit seen;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst.busy", 32'(busy), 32'd0);
      check_val("rst.done", 32'(done), 32'd0);
      check_val("rst.quo", quotient, 32'd0);
      check_val("rst.rem", remainder, 32'd0);
      check_val("rst.dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_div("d100_7", 32'd100, 32'd7, 1'b0);
      run_div("dm100_7", -32'sd100, 32'd7, 1'b0);
      run_div("d100_m7", 32'd100, -32'sd7, 1'b0);
      run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div("dmax_1", 32'h7FFF_FFFF, 32'd1, 1'b0);
      run_div("d5_0", 32'd5, 32'd0, 1'b0);
      run_div("d9_3", 32'd9, 32'd3, 1'b0);
      run_div("d3_10", 32'd3, 32'd10, 1'b0);
      run_div("dmin_0", 32'h8000_0000, 32'd0, 1'b0);
      run_div("inject", 32'd100, 32'd7, 1'b1);

      // start held high: back-to-back divisions, one every 37 cycles
      @(negedge clk);
      start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk); #1;
      k1 = 0; k2 = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done) begin
            if (k1 == 0) k1 = k;
            else begin k2 = k; break; end
         end
      end
      start = 1'b0;
      check_val("held.lat1", 32'(k1), 32'd35);
      check_val("held.period", 32'(k2 - k1), 32'd37);
      check_val("held.quo", quotient, 32'd333);
      check_val("held.rem", remainder, 32'd1);
      repeat (2) @(posedge clk);

      // asynchronous reset in the middle of a division
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst.busy", 32'(busy), 32'd0);
      check_val("mid_rst.done", 32'(done), 32'd0);
      check_val("mid_rst.quo", quotient, 32'd0);
      check_val("mid_rst.rem", remainder, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      check_val("mid_rst.quiet", 32'(seen), 32'd0);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 4))
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 20));
            2: b = -32'($urandom_range(1, 20));
            3: b = a >> $urandom_range(0, 31);
            default: b = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'hFFFF_FFFF;
         endcase
         run_div($sformatf("rnd%0d", i), a, b, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
